// File: rtl/seg_cnt.sv
// Two-digit BCD up-counter with an enable-gated prescaler and on-chip 7-segment decode.
// Segment bit order is {g,f,e,d,c,b,a}; SEG_ACTIVE_LOW inverts every segment output.
module seg_cnt #(
    parameter int DIV            = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] seg0,
    output logic [6:0] seg1
);

    localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(DIV - 1);
    localparam logic [6:0]     INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_next;
    logic [3:0]    ones;
    logic [3:0]    ones_next;
    logic [3:0]    tens;
    logic [3:0]    tens_next;
    logic          tick;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Prescaler advance and BCD carry chain; a disabled cycle keeps the partial prescale.
    always_comb begin
        pre_next  = pre;
        ones_next = ones;
        tens_next = tens;
        tick      = 1'b0;
        if (en) begin
            if (pre == PMAX) begin
                pre_next = '0;
                tick     = 1'b1;
            end else begin
                pre_next = pre + 1'b1;
            end
        end else begin
            pre_next = pre;
        end
        if (tick) begin
            if (ones == 4'd9) begin
                ones_next = 4'd0;
                if (tens == 4'd9) begin
                    tens_next = 4'd0;
                end else begin
                    tens_next = tens + 4'd1;
                end
            end else begin
                ones_next = ones + 4'd1;
            end
        end else begin
            ones_next = ones;
        end
    end

    // State registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            ones <= 4'd0;
            tens <= 4'd0;
        end else begin
            pre  <= pre_next;
            ones <= ones_next;
            tens <= tens_next;
        end
    end

    assign seg0 = seg_decode(ones) ^ INV;
    assign seg1 = seg_decode(tens) ^ INV;

endmodule

// File: tb/tb_seg_cnt.sv
// Directed self-checking bench for seg_cnt: DIV=4 main instance plus DIV=1 and
// active-low variants, all driven from one linear stimulus sequence.
module tb_seg_cnt;

    logic       clk = 1'b0;
    logic       rst, en, rst1, en1, rst_al, en_al;
    logic [6:0] seg0, seg1, seg0_1, seg1_1, seg0_al, seg1_al;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    seg_cnt #(.DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .seg0(seg0), .seg1(seg1)
    );
    seg_cnt #(.DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .seg0(seg0_1), .seg1(seg1_1)
    );
    seg_cnt #(.DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst_al), .en(en_al), .seg0(seg0_al), .seg1(seg1_al)
    );

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; rst1 = 1'b1; en1 = 1'b0; rst_al = 1'b1; en_al = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_seg0", seg0, 7'h3F);
        check("reset_async_seg1", seg1, 7'h3F);
        check("al_reset_seg0", seg0_al, 7'h40);
        check("al_reset_seg1", seg1_al, 7'h40);
        step(3);
        check("reset_hold_seg0", seg0, 7'h3F);
        check("reset_hold_seg1", seg1, 7'h3F);

        rst = 1'b0; rst1 = 1'b0; rst_al = 1'b0;
        step(50);
        check("en_low_50_seg0", seg0, 7'h3F);
        check("div1_en_low_seg0", seg0_1, 7'h3F);

        en = 1'b1; en1 = 1'b1; en_al = 1'b1;
        step(1);
        check("div1_edge1_seg0", seg0_1, 7'h06);
        step(1);
        check("div1_edge2_seg0", seg0_1, 7'h5B);
        step(1);
        check("div4_edge3_seg0", seg0, 7'h3F);
        step(1);
        check("div4_edge4_seg0", seg0, 7'h06);
        check("al_tick1_seg0", seg0_al, 7'h79);
        check("al_tick1_seg1", seg1_al, 7'h40);
        check("div1_edge4_seg0", seg0_1, 7'h66);
        en1 = 1'b0;
        step(4);
        check("div4_edge8_seg0", seg0, 7'h5B);
        check("div1_hold_seg0", seg0_1, 7'h66);
        en1 = 1'b1;
        step(4);
        check("div4_edge12_seg0", seg0, 7'h4F);
        check("div1_count8_seg0", seg0_1, 7'h7F);

        step(28);
        check("carry10_seg1", seg1, 7'h06);
        check("carry10_seg0", seg0, 7'h3F);
        step(356);
        check("count99_seg1", seg1, 7'h6F);
        check("count99_seg0", seg0, 7'h6F);

        step(2);
        en = 1'b0;
        step(7);
        check("pause_seg0", seg0, 7'h6F);
        check("pause_seg1", seg1, 7'h6F);
        en = 1'b1;
        step(1);
        check("resume_edge1_seg0", seg0, 7'h6F);
        step(1);
        check("wrap100_seg0", seg0, 7'h3F);
        check("wrap100_seg1", seg1, 7'h3F);
        step(4);
        check("tick101_seg0", seg0, 7'h06);
        check("tick101_seg1", seg1, 7'h3F);

        step(144);
        check("count37_seg1", seg1, 7'h4F);
        check("count37_seg0", seg0, 7'h07);
        step(2);
        rst = 1'b1;
        #1;
        check("midreset_async_seg0", seg0, 7'h3F);
        check("midreset_async_seg1", seg1, 7'h3F);
        step(2);
        check("midreset_en_hold_seg0", seg0, 7'h3F);
        rst = 1'b0;
        step(3);
        check("restart_edge3_seg0", seg0, 7'h3F);
        step(1);
        check("restart_edge4_seg0", seg0, 7'h06);
        check("restart_edge4_seg1", seg1, 7'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
